nice_rsp_sequencer: RTL and testbench

- Write-back stage between the execution sources (CSR unit, MMA unit) and the NICE response port.
- Records the source of every accepted NICE instruction in issue order.
- Accepts a result only from the source whose instruction is oldest, so responses always leave in program order.
- Drives nice_rsp_* through a one-entry registered output stage, and exposes occupancy for mem-holdup and active tracking.

---
 rtl/nice_rsp_sequencer_if.sv | 27 ++
 rtl/nice_rsp_sequencer.sv | 69 ++++++
 tb/tb_nice_rsp_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nice_rsp_sequencer_if.sv
// nice_rsp_sequencer_if: issue tags, CSR/MMA write-back and NICE response handshakes
//   issue_*  : decode pushes one order tag per response-producing instruction
//   csr_wb_* : CSR unit result, mma_wb_* : MMA completion (bits[1:0] error code)
//   nice_rsp_*: registered in-order response towards the core
interface nice_rsp_sequencer_if #(parameter int DW = 32);
  logic issue_valid;
  logic issue_ready;
  logic issue_is_mma;
  logic csr_wb_valid;
  logic csr_wb_ready;
  logic [DW-1:0] csr_wb_data;
  logic mma_wb_valid;
  logic mma_wb_ready;
  logic [DW-1:0] mma_wb_data;
  logic nice_rsp_valid;
  logic nice_rsp_ready;
  logic [DW-1:0] nice_rsp_rdat;
  logic nice_rsp_err;
  modport slave (
    input issue_valid, issue_is_mma, csr_wb_valid, csr_wb_data, mma_wb_valid, mma_wb_data, nice_rsp_ready,
    output issue_ready, csr_wb_ready, mma_wb_ready, nice_rsp_valid, nice_rsp_rdat, nice_rsp_err
  );
  modport master (
    output issue_valid, issue_is_mma, csr_wb_valid, csr_wb_data, mma_wb_valid, mma_wb_data, nice_rsp_ready,
    input issue_ready, csr_wb_ready, mma_wb_ready, nice_rsp_valid, nice_rsp_rdat, nice_rsp_err
  );
endinterface

// File: rtl/nice_rsp_sequencer.sv
// nice_rsp_sequencer: in-order write-back of CSR/MMA results onto the NICE response port
//   clk, rst    : clock, synchronous active-high reset
//   bus         : issue / csr_wb / mma_wb / nice_rsp handshakes (slave side)
//   outstanding : order-tag count plus response-register occupancy, busy = outstanding != 0
//   proto_err   : sticky, a source offered a result while not owning the oldest tag
module nice_rsp_sequencer #(
  parameter int DW = 32,
  parameter int ORD_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  nice_rsp_sequencer_if.slave bus,
  output logic [$clog2(ORD_DEPTH)+1:0] outstanding,
  output logic busy,
  output logic proto_err
);
  localparam int AW = $clog2(ORD_DEPTH);
  logic [ORD_DEPTH-1:0] tags;
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  logic ov, oerr;
  logic [DW-1:0] odata;
  logic head_is_mma, out_free, empty, push, csr_hs, mma_hs, pop, bad;
  always_comb begin
    empty = count == '0;
    head_is_mma = tags[rd];
    out_free = !ov || bus.nice_rsp_ready;
    bus.issue_ready = count != (AW+1)'(ORD_DEPTH);
    bus.csr_wb_ready = !empty && !head_is_mma && out_free;
    bus.mma_wb_ready = !empty && head_is_mma && out_free;
    push = bus.issue_valid && bus.issue_ready;
    csr_hs = bus.csr_wb_valid && bus.csr_wb_ready;
    mma_hs = bus.mma_wb_valid && bus.mma_wb_ready;
    pop = csr_hs || mma_hs;
    bad = (bus.csr_wb_valid && (empty || head_is_mma)) || (bus.mma_wb_valid && (empty || !head_is_mma));
    bus.nice_rsp_valid = ov;
    bus.nice_rsp_rdat = odata;
    bus.nice_rsp_err = oerr;
    outstanding = (AW+2)'(count) + (AW+2)'(ov);
    busy = outstanding != '0;
  end
  // tag storage needs no reset: entries are only read when count says they are live
  always_ff @(posedge clk)
    if (push) tags[wr] <= bus.issue_is_mma;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      ov <= 1'b0;
      odata <= '0;
      oerr <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      // a capture wins over a drain so back-to-back results reload without a bubble
      if (pop) begin
        ov <= 1'b1;
        odata <= csr_hs ? bus.csr_wb_data : bus.mma_wb_data;
        oerr <= mma_hs && (bus.mma_wb_data[1:0] != 2'b00);
      end else if (ov && bus.nice_rsp_ready) begin
        ov <= 1'b0;
      end
      proto_err <= proto_err || bad;
    end
  end
endmodule

// File: tb/tb_nice_rsp_sequencer.sv
// tb_nice_rsp_sequencer: randomized and directed checks against a queue-based response model
module tb_nice_rsp_sequencer;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  nice_rsp_sequencer_if #(.DW(DW)) bif ();
  logic [3:0] outstanding;
  logic busy, proto_err;
  nice_rsp_sequencer #(.DW(DW), .ORD_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif),
    .outstanding(outstanding),
    .busy(busy),
    .proto_err(proto_err)
  );
  typedef struct packed {logic [DW-1:0] d; logic e;} rsp_t;
  int checks = 0;
  int errors = 0;
  bit q[$];
  bit m_have, m_err, m_proto, m_live, m_csr_hs, m_mma_hs;
  logic [DW-1:0] m_data;
  logic [DW-1:0] seq;
  rsp_t got[$];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic idle();
    bif.issue_valid = 0;
    bif.issue_is_mma = 0;
    bif.csr_wb_valid = 0;
    bif.csr_wb_data = '0;
    bif.mma_wb_valid = 0;
    bif.mma_wb_data = '0;
    bif.nice_rsp_ready = 0;
  endtask
  // one clock: compare at the falling edge, advance the model, return just after the rising edge
  task automatic cycle();
    bit full, empty, of, cr, mr;
    @(negedge clk);
    full = q.size() == DEPTH;
    empty = q.size() == 0;
    of = !m_have || bif.nice_rsp_ready;
    cr = !empty && !q[0] && of;
    mr = !empty && q[0] && of;
    if (m_live) begin
      chk("issue_ready", bif.issue_ready, !full);
      chk("csr_wb_ready", bif.csr_wb_ready, cr);
      chk("mma_wb_ready", bif.mma_wb_ready, mr);
      chk("nice_rsp_valid", bif.nice_rsp_valid, m_have);
      if (m_have) begin
        chk("nice_rsp_rdat", bif.nice_rsp_rdat, m_data);
        chk("nice_rsp_err", bif.nice_rsp_err, m_err);
      end
      chk("outstanding", outstanding, q.size() + int'(m_have));
      chk("busy", busy, (q.size() + int'(m_have)) != 0);
      chk("proto_err", proto_err, m_proto);
      if (bif.nice_rsp_valid && bif.nice_rsp_ready) got.push_back({bif.nice_rsp_rdat, bif.nice_rsp_err});
    end
    m_csr_hs = bif.csr_wb_valid && cr;
    m_mma_hs = bif.mma_wb_valid && mr;
    if (rst) begin
      q.delete();
      m_have = 0;
      m_proto = 0;
      m_live = 1;
      m_csr_hs = 0;
      m_mma_hs = 0;
    end else if (m_live) begin
      if ((bif.csr_wb_valid && (empty || q[0])) || (bif.mma_wb_valid && (empty || !q[0]))) m_proto = 1;
      if (m_csr_hs || m_mma_hs) begin
        m_have = 1;
        m_data = m_csr_hs ? bif.csr_wb_data : bif.mma_wb_data;
        m_err = m_mma_hs && (bif.mma_wb_data[1:0] != 2'b00);
        void'(q.pop_front());
      end else if (m_have && bif.nice_rsp_ready) begin
        m_have = 0;
      end
      if (bif.issue_valid && !full) q.push_back(bif.issue_is_mma);
    end
    @(posedge clk);
    #1;
  endtask
  // sources offer a result only for the oldest tag and hold it until accepted
  task automatic serve(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      if (m_csr_hs) bif.csr_wb_valid = 0;
      if (m_mma_hs) bif.mma_wb_valid = 0;
      if (!bif.csr_wb_valid && !bif.mma_wb_valid && q.size() != 0 && (!rnd || $urandom_range(1, 0) == 1)) begin
        if (q[0]) begin
          bif.mma_wb_valid = 1;
          bif.mma_wb_data = seq;
        end else begin
          bif.csr_wb_valid = 1;
          bif.csr_wb_data = seq;
        end
        seq = rnd ? $urandom : seq + 1;
      end
      if (rnd) begin
        bif.nice_rsp_ready = $urandom_range(3, 0) != 0;
        bif.issue_valid = $urandom_range(1, 0) == 1;
        bif.issue_is_mma = $urandom_range(1, 0) == 1;
      end
      cycle();
    end
  endtask
  task automatic push_tags(int n, bit [3:0] pat);
    bif.issue_valid = 1;
    for (int i = 0; i < n; i++) begin
      bif.issue_is_mma = pat[i];
      cycle();
    end
    bif.issue_valid = 0;
    bif.issue_is_mma = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask
  initial begin
    logic [DW-1:0] held;
    m_live = 0;
    seq = '0;
    do_reset();
    chk("rst_issue_ready", bif.issue_ready, 1);
    chk("rst_valid", bif.nice_rsp_valid, 0);
    chk("rst_rdat", bif.nice_rsp_rdat, 0);
    chk("rst_err", bif.nice_rsp_err, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_readys", {bif.csr_wb_ready, bif.mma_wb_ready}, 0);
    cycle();
    push_tags(1, 4'b0000);
    chk("t2_out_push", outstanding, 1);
    bif.csr_wb_valid = 1;
    bif.csr_wb_data = 32'h0000_00A5;
    chk("t2_csr_ready", bif.csr_wb_ready, 1);
    cycle();
    bif.csr_wb_valid = 0;
    chk("t2_valid", bif.nice_rsp_valid, 1);
    chk("t2_rdat", bif.nice_rsp_rdat, 32'hA5);
    chk("t2_err", bif.nice_rsp_err, 0);
    chk("t2_out_cap", outstanding, 1);
    bif.nice_rsp_ready = 1;
    cycle();
    chk("t2_out_drain", outstanding, 0);
    chk("t2_valid_drain", bif.nice_rsp_valid, 0);
    push_tags(2, 4'b0001);
    got.delete();
    bif.csr_wb_valid = 1;
    bif.csr_wb_data = 32'h11;
    chk("t3_csr_held", bif.csr_wb_ready, 0);
    cycle();
    chk("t3_proto", proto_err, 1);
    cycle();
    bif.mma_wb_valid = 1;
    bif.mma_wb_data = 32'h2;
    chk("t3_mma_ready", bif.mma_wb_ready, 1);
    cycle();
    bif.mma_wb_valid = 0;
    cycle();
    bif.csr_wb_valid = 0;
    cycle();
    cycle();
    chk("t3_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("t3_r0", got[0], {32'h2, 1'b1});
      chk("t3_r1", got[1], {32'h11, 1'b0});
    end
    do_reset();
    bif.nice_rsp_ready = 0;
    push_tags(4, 4'b0000);
    chk("t4_full_ready", bif.issue_ready, 0);
    chk("t4_full_out", outstanding, 4);
    bif.issue_valid = 1;
    cycle();
    bif.issue_valid = 0;
    chk("t4_no_push", outstanding, 4);
    for (int b = 0; b < 2; b++) begin
      if (b == 1) push_tags(4, 4'b1101);
      got.delete();
      bif.nice_rsp_ready = 1;
      seq = b == 0 ? 32'h100 : 32'h200;
      serve(8, 0);
      chk("t4_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
        chk("t4_rsp", got[i], b == 0 ? {32'h100 + i, 1'b0} : {32'h200 + i, i >= 2});
      bif.nice_rsp_ready = 0;
    end
    bif.nice_rsp_ready = 1;
    push_tags(3, 4'b0000);
    seq = 32'h300;
    for (int i = 0; i < 3; i++) begin
      serve(1, 0);
      chk("t5_b2b_valid", bif.nice_rsp_valid, 1);
      chk("t5_b2b_rdat", bif.nice_rsp_rdat, 32'h300 + i);
    end
    serve(2, 0);
    push_tags(2, 4'b0000);
    seq = 32'h400;
    serve(1, 0);
    bif.nice_rsp_ready = 0;
    held = bif.nice_rsp_rdat;
    chk("t5_held_val", held, 32'h400);
    for (int i = 0; i < 3; i++) begin
      serve(1, 0);
      chk("t5_stall_rdat", bif.nice_rsp_rdat, 32'h400);
      chk("t5_stall_ready", bif.csr_wb_ready, 0);
    end
    bif.nice_rsp_ready = 1;
    serve(4, 0);
    bif.nice_rsp_ready = 0;
    push_tags(4, 4'b0000);
    seq = 32'h500;
    serve(1, 0);
    chk("t6_pre_out", outstanding, 4);
    do_reset();
    chk("t6_valid", bif.nice_rsp_valid, 0);
    chk("t6_out", outstanding, 0);
    chk("t6_issue_ready", bif.issue_ready, 1);
    got.delete();
    bif.nice_rsp_ready = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("t6_no_stale", got.size(), 0);
    seq = $urandom;
    serve(3000, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
